// File: rtl/par_check_rx_if.sv
// Serial receive bus for par_check_rx: line/strobe toward the receiver, recovered word and status back.
// The receiver drives data_out, data_valid, par_err, frame_err, busy and err_count.
interface par_check_rx_if #(
   parameter int DATA_W = 3,
   parameter int CNT_W  = 8
);
   logic              din;
   logic              bit_en;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              par_err;
   logic              frame_err;
   logic              busy;
   logic [CNT_W-1:0]  err_count;

   modport master (
      output din,
      output bit_en,
      input  data_out,
      input  data_valid,
      input  par_err,
      input  frame_err,
      input  busy,
      input  err_count
   );

   modport slave (
      input  din,
      input  bit_en,
      output data_out,
      output data_valid,
      output par_err,
      output frame_err,
      output busy,
      output err_count
   );
endinterface

// File: rtl/par_check_rx.sv
// Parity-checking serial receiver: start, DATA_W bits LSB first, parity, stop.
// Delivers each frame with a one-cycle valid pulse, parity/framing flags and a saturating error count.
module par_check_rx #(
   parameter int DATA_W     = 3,
   parameter int PARITY_ODD = 0,
   parameter int CNT_W      = 8
) (
   input logic           clk,
   input logic           rst,
   par_check_rx_if.slave bus
);

   localparam int BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);
   localparam logic PAR_INV = (PARITY_ODD != 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   function automatic logic expected_par(input logic [DATA_W-1:0] d);
      return (^d) ^ PAR_INV;
   endfunction

   // Counter holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [BCNT_W-1:0]   cnt_q, cnt_d;
   logic                rx_par_q, rx_par_d;
   logic                frame_done;
   logic                par_err_d;
   logic                frame_err_d;

   logic [DATA_W-1:0]   data_p1;
   logic                vld_p1;
   logic                par_err_p1;
   logic                frame_err_p1;
   logic [CNT_W-1:0]    err_cnt_p1;

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      rx_par_d    = rx_par_q;
      frame_done  = 1'b0;
      par_err_d   = rx_par_q ^ expected_par(shift_q);
      frame_err_d = ~bus.din;

      if (bus.bit_en) begin
         case (state_q)
            IDLE: begin
               if (!bus.din) begin
                  state_d = DATA;
                  cnt_d   = '0;
               end
            end
            DATA: begin
               // Shift toward bit 0 so the first received bit ends up as the LSB.
               shift_d             = shift_q >> 1;
               shift_d[DATA_W-1]   = bus.din;
               cnt_d               = cnt_q + 1'b1;
               if (cnt_q == LAST_BIT) begin
                  state_d = PARITY;
               end
            end
            PARITY: begin
               rx_par_d = bus.din;
               state_d  = STOP;
            end
            STOP: begin
               frame_done = 1'b1;
               state_d    = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         rx_par_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         rx_par_q <= rx_par_d;
      end
   end

   // Stage 1: frame result registered on the stop-bit edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_p1      <= '0;
         vld_p1       <= 1'b0;
         par_err_p1   <= 1'b0;
         frame_err_p1 <= 1'b0;
         err_cnt_p1   <= '0;
      end else begin
         vld_p1       <= frame_done;
         par_err_p1   <= frame_done & par_err_d;
         frame_err_p1 <= frame_done & frame_err_d;
         if (frame_done) begin
            data_p1 <= shift_q;
            if (par_err_d || frame_err_d) begin
               err_cnt_p1 <= sat_inc(err_cnt_p1);
            end
         end
      end
   end

   assign bus.data_out   = data_p1;
   assign bus.data_valid = vld_p1;
   assign bus.par_err    = par_err_p1;
   assign bus.frame_err  = frame_err_p1;
   assign bus.busy       = (state_q != IDLE);
   assign bus.err_count  = err_cnt_p1;

endmodule

// File: tb/tb_par_check_rx.sv
// Directed bench for par_check_rx: an even-parity instance (CNT_W=8) and an odd-parity instance (CNT_W=2).
module tb_par_check_rx;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   pulses_a = 0;
   int   pulses_b = 0;

   par_check_rx_if #(.DATA_W(3), .CNT_W(8)) bus_a ();
   par_check_rx_if #(.DATA_W(3), .CNT_W(2)) bus_b ();

   par_check_rx #(.DATA_W(3), .PARITY_ODD(0), .CNT_W(8)) dut_even (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a)
   );

   par_check_rx #(.DATA_W(3), .PARITY_ODD(1), .CNT_W(2)) dut_odd (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus_a.data_valid === 1'b1) pulses_a++;
      if (bus_b.data_valid === 1'b1) pulses_b++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int which, input logic d, input logic en);
      if (which == 0) begin
         bus_a.din    = d;
         bus_a.bit_en = en;
      end else begin
         bus_b.din    = d;
         bus_b.bit_en = en;
      end
   endtask

   // Idle gap cycles carry the inverted bit so an ignored strobe would corrupt the word.
   task automatic strobe(input int which, input logic d, input int gap);
      for (int g = 0; g < gap; g++) begin
         drive(which, ~d, 1'b0);
         tick();
      end
      drive(which, d, 1'b1);
      tick();
   endtask

   task automatic send_frame(input int which, input logic [2:0] data, input logic par,
                             input logic stop, input int gap);
      strobe(which, 1'b0, gap);
      for (int i = 0; i < 3; i++) strobe(which, data[i], gap);
      strobe(which, par, gap);
      strobe(which, stop, gap);
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      drive(0, 1'b1, 1'b0);
      drive(1, 1'b1, 1'b0);
      tick();
      tick();
      rst_a = 1'b0;
      rst_b = 1'b0;

      check("rst_data_out",   32'(bus_a.data_out),   32'h0);
      check("rst_data_valid", 32'(bus_a.data_valid), 32'h0);
      check("rst_par_err",    32'(bus_a.par_err),    32'h0);
      check("rst_frame_err",  32'(bus_a.frame_err),  32'h0);
      check("rst_busy",       32'(bus_a.busy),       32'h0);
      check("rst_err_count",  32'(bus_a.err_count),  32'h0);
      check("rst_b_err_count", 32'(bus_b.err_count), 32'h0);

      // Idle line
      drive(0, 1'b1, 1'b1);
      for (int c = 0; c < 20; c++) tick();
      check("idle_pulses",    32'(pulses_a),         32'd0);
      check("idle_busy",      32'(bus_a.busy),       32'h0);
      check("idle_err_count", 32'(bus_a.err_count),  32'h0);
      check("idle_data_out",  32'(bus_a.data_out),   32'h0);

      // Good even frame: data 1,0,1 -> 3'b101, parity 0
      strobe(0, 1'b0, 0);
      check("good_busy_after_start", 32'(bus_a.busy), 32'h1);
      strobe(0, 1'b1, 0);
      strobe(0, 1'b0, 0);
      strobe(0, 1'b1, 0);
      strobe(0, 1'b0, 0);
      check("good_no_early_valid", 32'(bus_a.data_valid), 32'h0);
      strobe(0, 1'b1, 0);
      check("good_data_out",   32'(bus_a.data_out),   32'h5);
      check("good_valid",      32'(bus_a.data_valid), 32'h1);
      check("good_par_err",    32'(bus_a.par_err),    32'h0);
      check("good_frame_err",  32'(bus_a.frame_err),  32'h0);
      check("good_err_count",  32'(bus_a.err_count),  32'h0);
      check("good_busy_low",   32'(bus_a.busy),       32'h0);
      drive(0, 1'b1, 1'b1);
      tick();
      check("good_valid_one_cycle", 32'(bus_a.data_valid), 32'h0);
      check("good_pulses",          32'(pulses_a),         32'd1);

      // Parity error then back-to-back good frame 1,1,0 -> 3'b011
      send_frame(0, 3'b101, 1'b1, 1'b1, 0);
      check("perr_valid",     32'(bus_a.data_valid), 32'h1);
      check("perr_par_err",   32'(bus_a.par_err),    32'h1);
      check("perr_frame_err", 32'(bus_a.frame_err),  32'h0);
      check("perr_err_count", 32'(bus_a.err_count),  32'h1);
      send_frame(0, 3'b011, 1'b0, 1'b1, 0);
      check("b2b_data_out",   32'(bus_a.data_out),   32'h3);
      check("b2b_valid",      32'(bus_a.data_valid), 32'h1);
      check("b2b_par_err",    32'(bus_a.par_err),    32'h0);
      check("b2b_err_count",  32'(bus_a.err_count),  32'h1);
      drive(0, 1'b1, 1'b1);
      tick();
      check("b2b_pulses", 32'(pulses_a), 32'd3);

      // Framing error, strobe every 4th cycle: data 0,1,1 -> 3'b110, parity 0, stop 0
      strobe(0, 1'b0, 3);
      strobe(0, 1'b0, 3);
      strobe(0, 1'b1, 3);
      drive(0, 1'b0, 1'b0);
      tick();
      tick();
      check("ferr_busy_hold",  32'(bus_a.busy),       32'h1);
      check("ferr_no_valid",   32'(bus_a.data_valid), 32'h0);
      strobe(0, 1'b1, 1);
      strobe(0, 1'b0, 3);
      strobe(0, 1'b0, 3);
      check("ferr_data_out",   32'(bus_a.data_out),   32'h6);
      check("ferr_valid",      32'(bus_a.data_valid), 32'h1);
      check("ferr_frame_err",  32'(bus_a.frame_err),  32'h1);
      check("ferr_par_err",    32'(bus_a.par_err),    32'h0);
      check("ferr_err_count",  32'(bus_a.err_count),  32'h2);
      drive(0, 1'b1, 1'b1);
      tick();
      check("ferr_pulses", 32'(pulses_a), 32'd4);

      // Reset after the 2nd data bit, then a good frame 0,1,0 -> 3'b010, parity 1
      strobe(0, 1'b0, 0);
      strobe(0, 1'b1, 0);
      strobe(0, 1'b1, 0);
      rst_a = 1'b1;
      drive(0, 1'b0, 1'b1);
      tick();
      rst_a = 1'b0;
      check("mrst_busy",      32'(bus_a.busy),       32'h0);
      check("mrst_data_out",  32'(bus_a.data_out),   32'h0);
      check("mrst_err_count", 32'(bus_a.err_count),  32'h0);
      check("mrst_valid",     32'(bus_a.data_valid), 32'h0);
      drive(0, 1'b1, 1'b1);
      tick();
      send_frame(0, 3'b010, 1'b1, 1'b1, 0);
      check("mrst_good_data",     32'(bus_a.data_out),   32'h2);
      check("mrst_good_valid",    32'(bus_a.data_valid), 32'h1);
      check("mrst_good_par_err",  32'(bus_a.par_err),    32'h0);
      check("mrst_good_ferr",     32'(bus_a.frame_err),  32'h0);
      check("mrst_good_errcnt",   32'(bus_a.err_count),  32'h0);
      drive(0, 1'b1, 1'b1);
      tick();
      check("mrst_pulses", 32'(pulses_a), 32'd5);

      // Odd parity, 2-bit counter: data 000 with parity 0 is always wrong
      drive(1, 1'b1, 1'b1);
      tick();
      for (int k = 0; k < 5; k++) begin
         send_frame(1, 3'b000, 1'b0, 1'b1, 0);
         check("sat_valid",     32'(bus_b.data_valid), 32'h1);
         check("sat_par_err",   32'(bus_b.par_err),    32'h1);
         check("sat_err_count", 32'(bus_b.err_count),  (k < 3) ? 32'(k + 1) : 32'd3);
      end
      drive(1, 1'b1, 1'b1);
      tick();
      check("sat_pulses", 32'(pulses_b), 32'd5);
      check("sat_data_out", 32'(bus_b.data_out), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
